// File: rtl/dram_wbuf_resp.sv
// Data-RAM responder: writes post into a small FIFO and drain to a word array when no read is active;
// reads return data the same cycle, forwarded from the youngest matching buffered write if there is one.
module dram_wbuf_resp #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned IDX_W      = 12,
    parameter int unsigned WBUF_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          re_i,
    input  logic [ADDR_W-1:0]             raddr_i,
    output logic [DATA_W-1:0]             rdata_o,
    input  logic                          we_i,
    input  logic [ADDR_W-1:0]             waddr_i,
    input  logic [DATA_W-1:0]             wdata_i,
    output logic                          stall_o,
    output logic                          idle_o,
    output logic                          ovf_o,
    output logic [$clog2(WBUF_DEPTH):0]   count_o
);
    localparam int unsigned PTR_W = $clog2(WBUF_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q      [2**IDX_W];
    logic [IDX_W-1:0]  buf_idx_q  [WBUF_DEPTH];
    logic [DATA_W-1:0] buf_data_q [WBUF_DEPTH];

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             full, drain, enq;
    logic [IDX_W-1:0] widx, ridx;

    assign widx  = waddr_i[IDX_W+1:2];
    assign ridx  = raddr_i[IDX_W+1:2];
    assign full  = (count_q == CNT_W'(WBUF_DEPTH));
    // Reads own the array port, so a drain only happens in a read-free cycle.
    assign drain = (count_q != '0) && !re_i;
    assign enq   = we_i && (!full || drain);

    always_comb begin
        head_d  = drain ? head_q + PTR_W'(1) : head_q;
        tail_d  = enq   ? tail_q + PTR_W'(1) : tail_q;
        count_d = count_q;
        if (enq && !drain) begin
            count_d = count_q + CNT_W'(1);
        end else if (!enq && drain) begin
            count_d = count_q - CNT_W'(1);
        end
        ovf_d = ovf_q | (we_i && !enq);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Buffer slots and the array carry no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (enq) begin
            buf_idx_q[tail_q]  <= widx;
            buf_data_q[tail_q] <= wdata_i;
        end
        if (drain) begin
            mem_q[buf_idx_q[head_q]] <= buf_data_q[head_q];
        end
    end

    logic [PTR_W-1:0]  slot;
    logic              hit;
    logic [DATA_W-1:0] fwd;

    // Scan oldest to youngest so the last hit is the youngest matching write.
    always_comb begin
        slot    = '0;
        hit     = 1'b0;
        fwd     = '0;
        rdata_o = '0;
        for (int unsigned i = 0; i < WBUF_DEPTH; i++) begin
            slot = head_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (buf_idx_q[slot] == ridx)) begin
                hit = 1'b1;
                fwd = buf_data_q[slot];
            end
        end
        if (re_i) begin
            rdata_o = hit ? fwd : mem_q[ridx];
        end
    end

    assign stall_o = full;
    assign idle_o  = (count_q == '0);
    assign ovf_o   = ovf_q;
    assign count_o = count_q;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{raddr_i[ADDR_W-1:IDX_W+2], raddr_i[1:0],
                                waddr_i[ADDR_W-1:IDX_W+2], waddr_i[1:0]};
endmodule

// File: tb/tb_dram_wbuf_resp.sv
// Directed bench for dram_wbuf_resp: a queue/map model checked every cycle plus literal expectations.
module tb_dram_wbuf_resp;
    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        re_i = 1'b0;
    logic [31:0] raddr_i = '0;
    logic        we_i = 1'b0;
    logic [31:0] waddr_i = '0;
    logic [31:0] wdata_i = '0;
    logic [31:0] rdata_o;
    logic        stall_o, idle_o, ovf_o;
    logic [2:0]  count_o;

    dram_wbuf_resp #(
        .ADDR_W(32), .DATA_W(32), .IDX_W(12), .WBUF_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .re_i(re_i), .raddr_i(raddr_i), .rdata_o(rdata_o),
        .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
        .stall_o(stall_o), .idle_o(idle_o), .ovf_o(ovf_o), .count_o(count_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit started  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: ordered list of pending writes plus a map of words known to be in the array.
    typedef struct { int unsigned idx; logic [31:0] data; } ent_t;
    ent_t                 pend[$];
    logic [31:0]          amem [int unsigned];
    bit                   m_ovf = 1'b0;

    function automatic int unsigned word_of(input logic [31:0] a);
        return (a >> 2) & 32'h0000_0FFF;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pend.delete();
            m_ovf = 1'b0;
        end else begin
            bit do_drain, do_enq;
            ent_t e;
            do_drain = (pend.size() != 0) && !re_i;
            do_enq   = we_i && ((pend.size() < DEPTH) || do_drain);
            if (do_drain) begin
                e = pend.pop_front();
                amem[e.idx] = e.data;
            end
            if (do_enq) begin
                e.idx  = word_of(waddr_i);
                e.data = wdata_i;
                pend.push_back(e);
            end
            if (we_i && !do_enq) m_ovf = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (started && !rst) begin
            bit          known;
            logic [31:0] exp_rd;
            int unsigned w;
            known  = 1'b1;
            exp_rd = '0;
            if (re_i) begin
                w     = word_of(raddr_i);
                known = 1'b0;
                for (int k = pend.size() - 1; k >= 0; k--) begin
                    if (pend[k].idx == w) begin
                        exp_rd = pend[k].data;
                        known  = 1'b1;
                        break;
                    end
                end
                if (!known && amem.exists(w)) begin
                    exp_rd = amem[w];
                    known  = 1'b1;
                end
            end
            if (known) check("model_rdata", rdata_o, exp_rd);
            check("model_count", {29'd0, count_o}, pend.size());
            check("model_stall", {31'd0, stall_o}, {31'd0, pend.size() == DEPTH});
            check("model_idle",  {31'd0, idle_o},  {31'd0, pend.size() == 0});
            check("model_ovf",   {31'd0, ovf_o},   {31'd0, m_ovf});
        end
    end

    // Each step applies inputs just after a rising edge and returns at the following falling edge.
    task automatic step(input logic re, input logic [31:0] ra,
                        input logic we, input logic [31:0] wa, input logic [31:0] wd);
        @(posedge clk);
        #1;
        re_i = re; raddr_i = ra; we_i = we; waddr_i = wa; wdata_i = wd;
        @(negedge clk);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        re_i = 1'b0; we_i = 1'b0;
        rst  = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #12;
        check("rst_count", {29'd0, count_o}, 32'd0);
        check("rst_idle",  {31'd0, idle_o},  32'd1);
        check("rst_stall", {31'd0, stall_o}, 32'd0);
        check("rst_ovf",   {31'd0, ovf_o},   32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        started = 1'b1;

        // Write then read back from the array.
        step(1'b0, 32'h0, 1'b1, 32'h10, 32'hDEAD_BEEF);
        step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        check("wr_pending_count", {29'd0, count_o}, 32'd1);
        step(1'b1, 32'h10, 1'b0, 32'h0, 32'h0);
        check("wr_rd_data", rdata_o, 32'hDEAD_BEEF);
        check("wr_rd_idle", {31'd0, idle_o}, 32'd1);

        // Youngest-match forwarding while reads starve the drain.
        step(1'b1, 32'h20, 1'b1, 32'h20, 32'h1111);
        step(1'b1, 32'h20, 1'b1, 32'h20, 32'h2222);
        check("fwd_first", rdata_o, 32'h1111);
        step(1'b1, 32'h20, 1'b0, 32'h0, 32'h0);
        check("fwd_youngest", rdata_o, 32'h2222);
        check("fwd_count", {29'd0, count_o}, 32'd2);
        idle_cycles(2);
        step(1'b1, 32'h20, 1'b0, 32'h0, 32'h0);
        check("fwd_array_last_wins", rdata_o, 32'h2222);
        check("fwd_idle", {31'd0, idle_o}, 32'd1);

        // Fill, overflow, drain.
        for (int i = 0; i < 4; i++)
            step(1'b1, 32'h100, 1'b1, 32'h100 + 32'(4 * i), 32'(i + 1));
        step(1'b1, 32'h100, 1'b1, 32'h110, 32'h5);
        check("full_stall", {31'd0, stall_o}, 32'd1);
        check("full_count", {29'd0, count_o}, 32'd4);
        check("full_ovf_before", {31'd0, ovf_o}, 32'd0);
        step(1'b1, 32'h10C, 1'b0, 32'h0, 32'h0);
        check("ovf_set", {31'd0, ovf_o}, 32'd1);
        check("ovf_count_held", {29'd0, count_o}, 32'd4);
        check("ovf_fwd", rdata_o, 32'h4);
        idle_cycles(4);
        step(1'b1, 32'h100, 1'b0, 32'h0, 32'h0);
        check("ovf_drained_data", rdata_o, 32'h1);
        check("ovf_sticky", {31'd0, ovf_o}, 32'd1);
        check("ovf_drained_idle", {31'd0, idle_o}, 32'd1);

        do_reset();

        // Enqueue accepted while full because a drain happens the same cycle.
        for (int i = 0; i < 4; i++)
            step(1'b1, 32'h200, 1'b1, 32'h200 + 32'(4 * i), 32'hB0 + 32'(i));
        step(1'b0, 32'h0, 1'b1, 32'h40, 32'hA5);
        check("fd_stall", {31'd0, stall_o}, 32'd1);
        step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        check("fd_count", {29'd0, count_o}, 32'd4);
        check("fd_no_ovf", {31'd0, ovf_o}, 32'd0);
        idle_cycles(4);
        step(1'b1, 32'h40, 1'b0, 32'h0, 32'h0);
        check("fd_rd_a5", rdata_o, 32'hA5);
        step(1'b1, 32'h20C, 1'b0, 32'h0, 32'h0);
        check("fd_rd_last_fill", rdata_o, 32'hB3);

        // Same-cycle read and write to one word.
        step(1'b0, 32'h0, 1'b1, 32'h30, 32'h5);
        idle_cycles(1);
        step(1'b1, 32'h30, 1'b1, 32'h30, 32'h6);
        check("rw_same_old", rdata_o, 32'h5);
        step(1'b1, 32'h30, 1'b0, 32'h0, 32'h0);
        check("rw_same_new", rdata_o, 32'h6);
        check("rw_same_count", {29'd0, count_o}, 32'd1);
        idle_cycles(2);

        // Asynchronous reset with writes still buffered.
        step(1'b1, 32'h0, 1'b1, 32'h10, 32'h77);
        step(1'b1, 32'h0, 1'b1, 32'h20, 32'h88);
        step(1'b1, 32'h0, 1'b1, 32'h30, 32'h99);
        step(1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
        check("pre_rst_count", {29'd0, count_o}, 32'd3);
        #2;
        rst = 1'b1;
        #1;
        check("arst_count", {29'd0, count_o}, 32'd0);
        check("arst_idle",  {31'd0, idle_o},  32'd1);
        check("arst_ovf",   {31'd0, ovf_o},   32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b1, 32'h10, 1'b0, 32'h0, 32'h0);
        check("arst_rd_10", rdata_o, 32'hDEAD_BEEF);
        step(1'b1, 32'h20, 1'b0, 32'h0, 32'h0);
        check("arst_rd_20", rdata_o, 32'h2222);
        step(1'b1, 32'h30, 1'b0, 32'h0, 32'h0);
        check("arst_rd_30", rdata_o, 32'h6);
        step(1'b0, 32'h30, 1'b0, 32'h0, 32'h0);
        check("no_re_zero", rdata_o, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
